grid_loader: RTL and testbench

GRID_LOADER -- requirements
Module: grid_loader

---
 rtl/grid_pkg.sv | 21 ++
 rtl/grid_regfile.sv | 26 ++
 rtl/grid_loader.sv | 126 ++++++++++++
 tb/tb_grid_loader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// Shared constants and FSM state encoding for the 4x4 grid loader.
// Cell indices are row-major: index = (row-1)*GRID_DIM + (col-1).
package grid_pkg;

  localparam int GRID_DIM  = 4;
  localparam int NUM_CELLS = GRID_DIM * GRID_DIM;
  localparam int CELL_W    = 8;
  localparam int IDX_W     = $clog2(NUM_CELLS);
  localparam int CNT_W     = IDX_W + 1;
  localparam int DLY_W     = 4;

  typedef logic [CELL_W-1:0] cell_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } state_e;

endpackage

// File: rtl/grid_regfile.sv
// 16x8 cell storage: one indexed write port, all cells readable in parallel.
// Reset clears every cell asynchronously so the solver never sees stale data.
module grid_regfile
  import grid_pkg::*;
(
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          we_i,
  input  logic [IDX_W-1:0]              idx_i,
  input  logic [CELL_W-1:0]             wdata_i,
  output logic [NUM_CELLS-1:0][CELL_W-1:0] cells_o
);

  logic [NUM_CELLS-1:0][CELL_W-1:0] cells_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cells_q <= '0;
    end else if (we_i) begin
      cells_q[idx_i] <= wdata_i;
    end
  end

  assign cells_o = cells_q;

endmodule

// File: rtl/grid_loader.sv
// Loads 16 initial cell bytes over a valid/ready stream, then releases the
// solver reset RELEASE_DELAY cycles after the last byte is captured.
//
//   state  | meaning
//   IDLE   | waiting for START, solver held in reset
//   LOAD   | accepting bytes, COUNT = bytes taken so far
//   SETTLE | grid full, solver still in reset for RELEASE_DELAY cycles
//   RUN    | solver released, grid stable
module grid_loader
  import grid_pkg::*;
#(
  parameter int RELEASE_DELAY = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              START,
  input  logic [CELL_W-1:0] DIN,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  output logic [CELL_W-1:0] IN11,
  output logic [CELL_W-1:0] IN12,
  output logic [CELL_W-1:0] IN13,
  output logic [CELL_W-1:0] IN14,
  output logic [CELL_W-1:0] IN21,
  output logic [CELL_W-1:0] IN22,
  output logic [CELL_W-1:0] IN23,
  output logic [CELL_W-1:0] IN24,
  output logic [CELL_W-1:0] IN31,
  output logic [CELL_W-1:0] IN32,
  output logic [CELL_W-1:0] IN33,
  output logic [CELL_W-1:0] IN34,
  output logic [CELL_W-1:0] IN41,
  output logic [CELL_W-1:0] IN42,
  output logic [CELL_W-1:0] IN43,
  output logic [CELL_W-1:0] IN44,
  output logic              LOADED,
  output logic              SOLVER_RESET,
  output logic [CNT_W-1:0]  COUNT
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic               wr_en;
  logic [NUM_CELLS-1:0][CELL_W-1:0] cells;

  grid_regfile u_regfile (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .we_i    (wr_en),
    .idx_i   (count_q[IDX_W-1:0]),
    .wdata_i (DIN),
    .cells_o (cells)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      count_q <= '0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dly_q   <= dly_d;
    end
  end

  // START has priority over everything, including a handshake in the same cycle.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dly_d   = dly_q;
    wr_en   = 1'b0;
    if (START) begin
      state_d = LOAD;
      count_d = '0;
      dly_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: ;
        LOAD: begin
          if (DIN_VALID) begin
            wr_en   = 1'b1;
            count_d = count_q + CNT_W'(1);
            if (count_q == CNT_W'(NUM_CELLS - 1)) begin
              state_d = SETTLE;
              dly_d   = DLY_W'(RELEASE_DELAY - 1);
            end
          end
        end
        SETTLE: begin
          if (dly_q == '0) begin
            state_d = RUN;
          end else begin
            dly_d = dly_q - DLY_W'(1);
          end
        end
        RUN: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign DIN_READY    = (state_q == LOAD);
  assign LOADED       = (state_q == SETTLE) || (state_q == RUN);
  assign SOLVER_RESET = (state_q != RUN);
  assign COUNT        = count_q;

  assign IN11 = cells[0];
  assign IN12 = cells[1];
  assign IN13 = cells[2];
  assign IN14 = cells[3];
  assign IN21 = cells[4];
  assign IN22 = cells[5];
  assign IN23 = cells[6];
  assign IN24 = cells[7];
  assign IN31 = cells[8];
  assign IN32 = cells[9];
  assign IN33 = cells[10];
  assign IN34 = cells[11];
  assign IN41 = cells[12];
  assign IN42 = cells[13];
  assign IN43 = cells[14];
  assign IN44 = cells[15];

endmodule

// File: tb/tb_grid_loader.sv
// Self-checking bench for grid_loader against a transaction-level model.
module tb_grid_loader;

  localparam int RD = 2;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       START = 1'b0;
  logic [7:0] DIN = 8'h00;
  logic       DIN_VALID = 1'b0;
  logic       DIN_READY, LOADED, SOLVER_RESET;
  logic [4:0] COUNT;
  logic [7:0] IN11, IN12, IN13, IN14, IN21, IN22, IN23, IN24;
  logic [7:0] IN31, IN32, IN33, IN34, IN41, IN42, IN43, IN44;

  always #5 Clk = ~Clk;

  grid_loader #(.RELEASE_DELAY(RD)) dut (
    .Clk(Clk), .Reset(Reset), .START(START), .DIN(DIN), .DIN_VALID(DIN_VALID),
    .DIN_READY(DIN_READY),
    .IN11(IN11), .IN12(IN12), .IN13(IN13), .IN14(IN14),
    .IN21(IN21), .IN22(IN22), .IN23(IN23), .IN24(IN24),
    .IN31(IN31), .IN32(IN32), .IN33(IN33), .IN34(IN34),
    .IN41(IN41), .IN42(IN42), .IN43(IN43), .IN44(IN44),
    .LOADED(LOADED), .SOLVER_RESET(SOLVER_RESET), .COUNT(COUNT)
  );

  logic [7:0] dut_cells [16];
  assign dut_cells[0]  = IN11;  assign dut_cells[1]  = IN12;
  assign dut_cells[2]  = IN13;  assign dut_cells[3]  = IN14;
  assign dut_cells[4]  = IN21;  assign dut_cells[5]  = IN22;
  assign dut_cells[6]  = IN23;  assign dut_cells[7]  = IN24;
  assign dut_cells[8]  = IN31;  assign dut_cells[9]  = IN32;
  assign dut_cells[10] = IN33;  assign dut_cells[11] = IN34;
  assign dut_cells[12] = IN41;  assign dut_cells[13] = IN42;
  assign dut_cells[14] = IN43;  assign dut_cells[15] = IN44;

  // Model: mode 0 = waiting for START, 1 = collecting bytes, 2 = grid complete.
  logic [7:0] m_cells [16];
  int m_mode, m_cnt, m_age;
  int checks = 0;
  int errors = 0;

  function automatic bit exp_ready();
    return m_mode == 1;
  endfunction

  function automatic bit exp_loaded();
    return m_mode == 2;
  endfunction

  function automatic bit exp_sr();
    return !(m_mode == 2 && m_age >= RD);
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_cnt  = 0;
    m_age  = 0;
    for (int i = 0; i < 16; i++) m_cells[i] = 8'h00;
  endtask

  task automatic step(input bit st, input bit v, input logic [7:0] d);
    START = st;
    DIN_VALID = v;
    DIN = d;
    @(posedge Clk);
    if (st) begin
      m_mode = 1; m_cnt = 0; m_age = 0;
    end else if (m_mode == 1 && v) begin
      m_cells[m_cnt] = d;
      m_cnt++;
      if (m_cnt == 16) begin m_mode = 2; m_age = 0; end
    end else if (m_mode == 2 && m_age < 1000) begin
      m_age++;
    end
    #1;
  endtask

  task automatic apply_reset();
    START = 0; DIN_VALID = 0;
    #2 Reset = 1'b1;
    model_reset();
    @(posedge Clk); #1;
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    START = 0; DIN_VALID = 0;
    #2 Reset = 1'b1;
    #1;
    model_reset();
    checks++; if (SOLVER_RESET !== 1'b1) begin errors++; $display("FAIL reset_sr: got %b expected 1", SOLVER_RESET); end
    checks++; if (DIN_READY !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", DIN_READY); end
    checks++; if (LOADED !== 1'b0) begin errors++; $display("FAIL reset_loaded: got %b expected 0", LOADED); end
    checks++; if (COUNT !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", COUNT); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (dut_cells[i] !== 8'h00) begin errors++; $display("FAIL reset_cell%0d: got %h expected 00", i, dut_cells[i]); end
    end
    @(posedge Clk); #1;
    Reset = 1'b0;
    step(0, 1, 8'h42);
    checks++; if (DIN_READY !== 1'b0 || COUNT !== 5'd0) begin errors++; $display("FAIL idle_after_reset: ready %b count %0d expected 0 0", DIN_READY, COUNT); end
  endtask

  task automatic test_stream();
    int fall = -1;
    step(1, 0, 8'h00);
    checks++; if (DIN_READY !== 1'b1 || COUNT !== 5'd0) begin errors++; $display("FAIL stream_start: ready %b count %0d expected 1 0", DIN_READY, COUNT); end
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 8'(8'h10 + i));
      checks++; if (COUNT !== 5'(i + 1)) begin errors++; $display("FAIL stream_count: got %0d expected %0d", COUNT, i + 1); end
      checks++; if (LOADED !== (i == 15)) begin errors++; $display("FAIL stream_loaded at byte %0d: got %b expected %b", i, LOADED, (i == 15)); end
    end
    checks++; if (DIN_READY !== 1'b0) begin errors++; $display("FAIL stream_ready_after16: got %b expected 0", DIN_READY); end
    for (int n = 1; n <= 10; n++) begin
      step(0, n == 1, 8'h99);
      if (SOLVER_RESET === 1'b0 && fall < 0) fall = n;
    end
    checks++; if (fall != RD) begin errors++; $display("FAIL stream_sr_fall: got %0d cycles expected %0d", fall, RD); end
    checks++; if (COUNT !== 5'd16) begin errors++; $display("FAIL stream_count_sat: got %0d expected 16", COUNT); end
    checks++; if (IN11 !== 8'h10 || IN44 !== 8'h1F) begin errors++; $display("FAIL stream_corners: got %h %h expected 10 1f", IN11, IN44); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (dut_cells[i] !== m_cells[i]) begin errors++; $display("FAIL stream_cell%0d: got %h expected %h", i, dut_cells[i], m_cells[i]); end
    end
  endtask

  task automatic test_toggle();
    int first = -1;
    apply_reset();
    step(1, 0, 8'h00);
    for (int i = 0; i < 32; i++) begin
      step(0, (i % 2) == 0, 8'(8'h10 + i / 2));
      checks++; if (COUNT !== 5'(m_cnt)) begin errors++; $display("FAIL toggle_count: got %0d expected %0d", COUNT, m_cnt); end
      if (LOADED === 1'b1 && first < 0) first = i;
    end
    checks++; if (first != 30) begin errors++; $display("FAIL toggle_done_cycle: got %0d expected 30", first); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (dut_cells[i] !== 8'(8'h10 + i)) begin errors++; $display("FAIL toggle_cell%0d: got %h expected %h", i, dut_cells[i], 8'(8'h10 + i)); end
    end
  endtask

  task automatic test_restart();
    step(1, 0, 8'h00);
    for (int i = 0; i < 7; i++) step(0, 1, 8'($urandom));
    checks++; if (COUNT !== 5'd7) begin errors++; $display("FAIL restart_count7: got %0d expected 7", COUNT); end
    step(1, 0, 8'h00);
    checks++; if (COUNT !== 5'd0 || LOADED !== 1'b0 || SOLVER_RESET !== 1'b1) begin
      errors++; $display("FAIL restart_abort: count %0d loaded %b sr %b expected 0 0 1", COUNT, LOADED, SOLVER_RESET); end
    for (int i = 0; i < 7; i++) begin
      checks++; if (dut_cells[i] !== m_cells[i]) begin errors++; $display("FAIL restart_keep%0d: got %h expected %h", i, dut_cells[i], m_cells[i]); end
    end
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 8'hA5);
      checks++; if (COUNT !== 5'(i + 1) || LOADED !== (i == 15)) begin
        errors++; $display("FAIL restart_reload: count %0d loaded %b expected %0d %b", COUNT, LOADED, i + 1, (i == 15)); end
    end
    for (int i = 0; i < 16; i++) begin
      checks++; if (dut_cells[i] !== 8'hA5) begin errors++; $display("FAIL restart_cell%0d: got %h expected a5", i, dut_cells[i]); end
    end
  endtask

  task automatic test_start_collision();
    step(1, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 1, 8'(8'h31 + i));
    step(1, 1, 8'h77);
    checks++; if (COUNT !== 5'd0) begin errors++; $display("FAIL collide_count: got %0d expected 0", COUNT); end
    checks++; if (IN11 !== 8'h31) begin errors++; $display("FAIL collide_in11: got %h expected 31", IN11); end
    checks++; if (DIN_READY !== 1'b1) begin errors++; $display("FAIL collide_ready: got %b expected 1", DIN_READY); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (dut_cells[i] !== m_cells[i]) begin errors++; $display("FAIL collide_cell%0d: got %h expected %h", i, dut_cells[i], m_cells[i]); end
    end
  endtask

  task automatic test_async_reset();
    step(1, 0, 8'h00);
    for (int i = 0; i < 16; i++) step(0, 1, 8'($urandom_range(1, 255)));
    repeat (RD + 1) step(0, 0, 8'h00);
    checks++; if (SOLVER_RESET !== 1'b0 || LOADED !== 1'b1) begin errors++; $display("FAIL async_run: sr %b loaded %b expected 0 1", SOLVER_RESET, LOADED); end
    #3 Reset = 1'b1;
    #1;
    model_reset();
    checks++; if (SOLVER_RESET !== 1'b1 || LOADED !== 1'b0 || COUNT !== 5'd0) begin
      errors++; $display("FAIL async_outputs: sr %b loaded %b count %0d expected 1 0 0", SOLVER_RESET, LOADED, COUNT); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (dut_cells[i] !== 8'h00) begin errors++; $display("FAIL async_cell%0d: got %h expected 00", i, dut_cells[i]); end
    end
    @(posedge Clk); #1;
    Reset = 1'b0;
    for (int n = 0; n < 5; n++) begin
      step(0, 1, 8'($urandom_range(1, 255)));
      checks++; if (DIN_READY !== 1'b0 || COUNT !== 5'd0) begin errors++; $display("FAIL async_nostart: ready %b count %0d expected 0 0", DIN_READY, COUNT); end
    end
    for (int i = 0; i < 16; i++) begin
      checks++; if (dut_cells[i] !== 8'h00) begin errors++; $display("FAIL async_nowrite%0d: got %h expected 00", i, dut_cells[i]); end
    end
  endtask

  task automatic test_ignore_valid();
    step(0, 1, 8'hFF);
    checks++; if (DIN_READY !== 1'b0 || IN11 !== 8'h00) begin errors++; $display("FAIL ignore_idle: ready %b in11 %h expected 0 00", DIN_READY, IN11); end
    step(1, 0, 8'h00);
    for (int i = 0; i < 16; i++) step(0, 1, 8'($urandom_range(0, 254)));
    repeat (RD + 1) step(0, 0, 8'h00);
    for (int n = 0; n < 3; n++) begin
      step(0, 1, 8'hFF);
      checks++; if (DIN_READY !== 1'b0 || SOLVER_RESET !== 1'b0) begin errors++; $display("FAIL ignore_run: ready %b sr %b expected 0 0", DIN_READY, SOLVER_RESET); end
    end
    for (int i = 0; i < 16; i++) begin
      checks++; if (dut_cells[i] !== m_cells[i]) begin errors++; $display("FAIL ignore_cell%0d: got %h expected %h", i, dut_cells[i], m_cells[i]); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0, 8'($urandom));
      checks++; if (COUNT !== 5'(m_cnt)) begin errors++; $display("FAIL rand_count: got %0d expected %0d", COUNT, m_cnt); end
      checks++; if (DIN_READY !== exp_ready() || LOADED !== exp_loaded() || SOLVER_RESET !== exp_sr()) begin
        errors++; $display("FAIL rand_flags: ready/loaded/sr %b%b%b expected %b%b%b",
                           DIN_READY, LOADED, SOLVER_RESET, exp_ready(), exp_loaded(), exp_sr()); end
      for (int i = 0; i < 16; i++) begin
        checks++; if (dut_cells[i] !== m_cells[i]) begin errors++; $display("FAIL rand_cell%0d: got %h expected %h", i, dut_cells[i], m_cells[i]); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_toggle();
    test_restart();
    test_start_collision();
    test_async_reset();
    test_ignore_valid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
